// File: rtl/up_down_mode_counter.sv
// up_down_mode_counter: bounded up/down counter steered by a small direction FSM.
// Count range is [MIN_VAL, MAX_VAL]. A step either wraps modulo the range (WRAP=1)
// or saturates at the bound (WRAP=0). The counter also has a synchronous load and
// a clock enable.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   enable                - advances the FSM and datapath; when low, everything holds
//   up, down              - direction requests (both high counts as a conflict)
//   load, load_value      - synchronous load, clamped to the range; has priority over enable
//   step                  - step magnitude, zero-extended
//   count, state          - registered count and FSM state (IDLE=00, UP=01, DOWN=10)
//   at_max, at_min        - combinational compares of the registered count against the bounds
//   overflow, underflow   - registered one-cycle pulses on a wrapping or clamping step
module up_down_mode_counter #(
    parameter int unsigned W       = 8,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 2**W - 1,
    parameter int unsigned WRAP    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              up,
    input  logic              down,
    input  logic              load,
    input  logic [W-1:0]      load_value,
    input  logic [STEP_W-1:0] step,
    output logic [W-1:0]      count,
    output logic [1:0]        state,
    output logic              at_max,
    output logic              at_min,
    output logic              overflow,
    output logic              underflow
);

    // Two extra bits: one for carry out of the add, one for sign below zero.
    localparam int unsigned XW = W + 2;
    localparam logic signed [XW-1:0] MIN_X   = $signed(XW'(MIN_VAL));
    localparam logic signed [XW-1:0] MAX_X   = $signed(XW'(MAX_VAL));
    localparam logic signed [XW-1:0] RANGE_X = $signed(XW'(MAX_VAL - MIN_VAL + 1));

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic            overflow_d, underflow_d;
    logic            up_only, down_only;
    logic signed [XW-1:0] cur_x, step_x, sum_x, dif_x, load_x;

    assign up_only   = up & ~down;
    assign down_only = down & ~up;
    assign cur_x     = $signed(XW'(count_q));
    assign step_x    = $signed(XW'(step));
    assign sum_x     = cur_x + step_x;
    assign dif_x     = cur_x - step_x;
    assign load_x    = $signed(XW'(load_value));

    // Next-state and datapath. The step is applied according to the current
    // registered state, so a request moves the count one edge after it is seen.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (load) begin
            state_d = IDLE;
            if (load_x > MAX_X)
                count_d = W'(MAX_VAL);
            else if (load_x < MIN_X)
                count_d = W'(MIN_VAL);
            else
                count_d = load_value;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    if (up_only)
                        state_d = UP;
                    else if (down_only)
                        state_d = DOWN;
                    else
                        state_d = IDLE;
                end
                UP: begin
                    if (up_only)
                        state_d = UP;
                    else if (down_only)
                        state_d = DOWN;
                    else
                        state_d = IDLE;
                    if (sum_x > MAX_X) begin
                        overflow_d = 1'b1;
                        count_d    = (WRAP != 0) ? W'(sum_x - RANGE_X) : W'(MAX_VAL);
                    end else begin
                        count_d = W'(sum_x);
                    end
                end
                DOWN: begin
                    if (down_only)
                        state_d = DOWN;
                    else if (up_only)
                        state_d = UP;
                    else
                        state_d = IDLE;
                    if (dif_x < MIN_X) begin
                        underflow_d = 1'b1;
                        count_d     = (WRAP != 0) ? W'(dif_x + RANGE_X) : W'(MIN_VAL);
                    end else begin
                        count_d = W'(dif_x);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, count and event-flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= W'(MIN_VAL);
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            overflow  <= overflow_d;
            underflow <= underflow_d;
        end
    end

    assign count  = count_q;
    assign state  = 2'(state_q);
    assign at_max = (count_q == W'(MAX_VAL));
    assign at_min = (count_q == W'(MIN_VAL));

endmodule

// File: tb/tb_up_down_mode_counter.sv
// Directed bench: one wrapping and one saturating counter share the same stimulus.
// Both count over [10, 20]. Each vector's expected value is worked out by hand.
module tb_up_down_mode_counter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       up;
    logic       down;
    logic       load;
    logic [7:0] load_value;
    logic [3:0] step;

    logic [7:0] cnt_w, cnt_s;
    logic [1:0] st_w, st_s;
    logic       amax_w, amin_w, ovf_w, unf_w;
    logic       amax_s, amin_s, ovf_s, unf_s;

    int n_vec = 0;
    int n_err = 0;

    up_down_mode_counter #(.W(8), .STEP_W(4), .MIN_VAL(10), .MAX_VAL(20), .WRAP(1)) u_wrap (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .down(down),
        .load(load), .load_value(load_value), .step(step),
        .count(cnt_w), .state(st_w), .at_max(amax_w), .at_min(amin_w),
        .overflow(ovf_w), .underflow(unf_w)
    );

    up_down_mode_counter #(.W(8), .STEP_W(4), .MIN_VAL(10), .MAX_VAL(20), .WRAP(0)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .down(down),
        .load(load), .load_value(load_value), .step(step),
        .count(cnt_s), .state(st_s), .at_max(amax_s), .at_min(amin_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle, so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b0; down = 1'b0;
        load = 1'b0; load_value = 8'd0; step = 4'd1;
        #3;
        check("rst_count", cnt_w, 10);
        check("rst_state", st_w, 0);
        check("rst_at_min", amin_w, 1);
        check("rst_at_max", amax_w, 0);
        check("rst_ovf", ovf_w, 0);
        tick(); tick();
        reset = 1'b0;
        enable = 1'b1;

        // Asynchronous reset while counting up from 15.
        do_load(8'd15);
        check("load15", cnt_w, 15);
        up = 1'b1;
        tick();
        check("mid_state_up", st_w, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_count", cnt_w, 10);
        check("mid_rst_state", st_w, 0);
        check("mid_rst_at_min", amin_w, 1);
        up = 1'b0;
        tick();
        reset = 1'b0;

        // Hold up for four cycles from 10 with step 1.
        up = 1'b1;
        tick();
        check("up_s1_state", st_w, 1);
        check("up_s1_count", cnt_w, 10);
        tick(); check("up_c11", cnt_w, 11);
        tick(); check("up_c12", cnt_w, 12);
        tick(); check("up_c13", cnt_w, 13);
        up = 1'b0;
        tick();
        check("up_c14", cnt_w, 14);
        check("up_idle", st_w, 0);
        check("up_no_ovf", ovf_w, 0);
        tick();
        check("up_hold14", cnt_w, 14);

        // Step of 3 from 19: the wrapping counter goes to 11, the saturating one clamps to 20.
        step = 4'd3;
        do_load(8'd19);
        up = 1'b1;
        tick();
        up = 1'b0;
        tick();
        check("wrap_up_count", cnt_w, 11);
        check("wrap_up_ovf", ovf_w, 1);
        check("sat_up_count", cnt_s, 20);
        check("sat_up_ovf", ovf_s, 1);
        tick();
        check("wrap_ovf_pulse", ovf_w, 0);

        // Step of 3 down from 11: the wrapping counter goes to 19, the saturating one clamps to 10.
        do_load(8'd11);
        down = 1'b1;
        tick();
        check("down_state", st_w, 2);
        down = 1'b0;
        tick();
        check("wrap_dn_count", cnt_w, 19);
        check("wrap_dn_unf", unf_w, 1);
        check("sat_dn_count", cnt_s, 10);
        check("sat_dn_unf", unf_s, 1);
        tick();
        check("wrap_unf_pulse", unf_w, 0);

        // Saturating counter, step 5 from 18: two up steps, both flag overflow.
        step = 4'd5;
        do_load(8'd18);
        up = 1'b1;
        tick();
        tick();
        check("sat_up1_count", cnt_s, 20);
        check("sat_up1_ovf", ovf_s, 1);
        up = 1'b0;
        tick();
        check("sat_up2_count", cnt_s, 20);
        check("sat_up2_ovf", ovf_s, 1);
        check("sat_at_max", amax_s, 1);
        tick();
        check("sat_ovf_clear", ovf_s, 0);

        // Step 5 down from 12: saturating clamps to 10, wrapping goes 7 + 11 = 18.
        do_load(8'd12);
        down = 1'b1;
        tick();
        down = 1'b0;
        tick();
        check("sat_dn_count12", cnt_s, 10);
        check("sat_dn_unf12", unf_s, 1);
        check("sat_dn_at_min", amin_s, 1);
        check("wrap_dn_count12", cnt_w, 18);

        // Both requests high while IDLE: the FSM stays IDLE and the count holds.
        tick();
        up = 1'b1; down = 1'b1;
        tick();
        check("conflict_state", st_s, 0);
        check("conflict_count", cnt_s, 10);
        up = 1'b0; down = 1'b0;

        // Direct reversal from UP to DOWN.
        step = 4'd1;
        do_load(8'd15);
        up = 1'b1;
        tick();
        check("rev_state_up", st_w, 1);
        up = 1'b0; down = 1'b1;
        tick();
        check("rev_state_dn", st_w, 2);
        check("rev_count16", cnt_w, 16);
        tick();
        check("rev_count15", cnt_w, 15);
        down = 1'b0;
        tick();
        check("rev_count14", cnt_w, 14);
        check("rev_idle", st_w, 0);

        // Load while enable is low, entered from UP: the value is clamped and the state goes IDLE.
        up = 1'b1;
        tick();
        check("pre_load_up", st_w, 1);
        enable = 1'b0;
        do_load(8'd250);
        check("ld_clamp_count", cnt_w, 20);
        check("ld_clamp_state", st_w, 0);
        check("ld_no_ovf", ovf_w, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_count", cnt_s, 20);
            check("frz_state", st_s, 0);
            check("frz_ovf", ovf_s, 0);
        end
        up = 1'b0;

        // A load below the range clamps to MIN_VAL.
        do_load(8'd3);
        check("ld_low_clamp", cnt_w, 10);

        // A step of zero leaves the count unchanged and raises no flag, even at MAX_VAL.
        do_load(8'd20);
        enable = 1'b1; step = 4'd0; up = 1'b1;
        tick();
        tick();
        check("step0_count", cnt_s, 20);
        check("step0_ovf", ovf_s, 0);
        check("step0_ovf_w", ovf_w, 0);
        up = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
